// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM and a
// first-word-fall-through RX FIFO with framing-error and overflow pulses.
module uart_receiver #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 8
) (
  input  logic                         clk_sys_i,
  input  logic                         rst_sys_i,
  input  logic                         uart_rx_i,
  output logic [7:0]                   rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic [$clog2(FifoDepth):0]   rx_level_o,
  output logic                         rx_busy_o,
  output logic                         frame_err_o,
  output logic                         overflow_o
);

  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int AddrW      = $clog2(FifoDepth);

  localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic              prev_q;
  logic [2:0]        warm_q;
  logic              rx_s, fall_edge;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              half_done, bit_done;
  logic              cnt_clr, bit_clr, sample_data, push_req, frame_err_d;
  logic [AddrW:0]    wr_ptr_q, rd_ptr_q;
  logic [7:0]        mem [FifoDepth];
  logic              full, pop, do_push;

  // Edges are qualified only once sync and edge flops hold real line samples,
  // so a line still held low as reset releases does not look like a start bit.
  assign rx_s      = sync_q[1];
  assign fall_edge = warm_q[2] & prev_q & ~rx_s;
  assign half_done = (cnt_q == HalfLast);
  assign bit_done  = (cnt_q == BitLast);

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      warm_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop see the pre-edge value,
      // which is what makes this a real shift chain rather than one wire.
      sync_q <= {sync_q[0], uart_rx_i};
      prev_q <= sync_q[1];
      warm_q <= {warm_q[1:0], 1'b1};
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    // NOTE: the default assignment first keeps this combinational; a path that
    // skips the assignment would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall_edge) state_d = START;
      START: if (half_done) state_d = rx_s ? IDLE : DATA;
      DATA:  if (bit_done && bit_cnt_q == 3'd7) state_d = STOP;
      STOP:  if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr     = 1'b0;
    bit_clr     = 1'b0;
    sample_data = 1'b0;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
      end
      START: cnt_clr = half_done;
      DATA: begin
        cnt_clr     = bit_done;
        sample_data = bit_done;
      end
      STOP: begin
        cnt_clr     = bit_done;
        push_req    = bit_done & rx_s;
        frame_err_d = bit_done & ~rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  assign rx_busy_o = (state_q != IDLE);

  // Full when the wrap bits differ but the index bits match.
  assign full       = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign rx_valid_o = (wr_ptr_q != rd_ptr_q);
  assign pop        = rx_valid_o & rx_ready_i;
  assign do_push    = push_req & (~full | pop);
  assign rx_level_o = wr_ptr_q - rd_ptr_q;
  assign rx_data_o  = rx_valid_o ? mem[rd_ptr_q[AddrW-1:0]] : 8'h00;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + 1'b1;
      if (bit_clr)          bit_cnt_q <= '0;
      else if (sample_data) bit_cnt_q <= bit_cnt_q + 1'b1;
      if (sample_data) shift_q <= {rx_s, shift_q[7:1]};
      frame_err_o <= frame_err_d;
      overflow_o  <= push_req & full & ~pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers define what is valid and
  // rx_data_o is masked while empty, so resetting the array buys nothing.
  always_ff @(posedge clk_sys_i) begin
    if (do_push) mem[wr_ptr_q[AddrW-1:0]] <= shift_q;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter ClockFrequency, default 50_000_000: clk_sys_i frequency in Hz.
REQ-002 Parameter BaudRate, default 115_200: serial bit rate; ClksPerBit = ClockFrequency / BaudRate, integer division, truncated.
REQ-003 Parameter FifoDepth, default 8: RX FIFO entries; power of two, at least 2.
REQ-004 clk_sys_i  input  1  system clock; the block has this one clock only.
REQ-005 rst_sys_i  input  1  reset; synchronous and active-high.
REQ-006 uart_rx_i  input  1  serial line; asynchronous to clk_sys_i; idles high.
REQ-007 rx_data_o  output  8  byte at the FIFO head.
REQ-008 rx_valid_o  output  1  FIFO not empty; rx_data_o is valid.
REQ-009 rx_ready_i  input  1  consumer accepts the head byte.
REQ-010 rx_level_o  output  $clog2(FifoDepth)+1  number of bytes held in the FIFO.
REQ-011 rx_busy_o  output  1  frame reception in progress; FSM not in IDLE.
REQ-012 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-013 overflow_o  output  1  one-cycle pulse: received byte dropped because the FIFO was full.

Function
REQ-014 uart_rx_i SHALL pass through a 2-flop synchronizer; both flops reset to 1. An edge-detect flop behind the synchronizer also resets to 1.
REQ-015 Frame format SHALL be 8N1: start bit 0, 8 data bits sent LSB first, no parity, 1 stop bit (1).
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP and a bit-timing counter wide enough for ClksPerBit-1.
REQ-017 IDLE -> START SHALL occur on a synchronized falling edge (previous sample 1, current sample 0). The counter clears on this transition.
REQ-018 START SHALL count to ClksPerBit/2 - 1 (mid-bit) and then resample the line.
- Line 0: go to DATA, counter cleared.
- Line 1: glitch; return to IDLE with no output event.
REQ-019 DATA SHALL sample the line each time the counter reaches ClksPerBit-1, then clear the counter.
- Each sample is shifted in at bit 7 with a right shift, so the first bit received lands in bit 0.
- After the 8th sample, go to STOP.
REQ-020 STOP SHALL sample the line when the counter reaches ClksPerBit-1, then return to IDLE.
- Line 1: push the byte.
- Line 0: pulse frame_err_o and discard the byte.
REQ-021 After a framing error, a new frame SHALL start only after a fresh 1->0 edge, so a held-low break produces exactly one frame_err_o pulse.
REQ-022 The FIFO SHALL be first-word-fall-through.
- Pushed byte appears on rx_data_o, with rx_valid_o=1, in the cycle after the stop-bit sample, if the FIFO was empty.
REQ-023 Pop SHALL occur when rx_valid_o && rx_ready_i; the next entry (or rx_valid_o=0) is visible the following cycle.
REQ-024 Push to a full FIFO with no pop in the same cycle SHALL drop the byte and pulse overflow_o; FIFO contents are unchanged.
REQ-025 Simultaneous push and pop when full SHALL accept both; level unchanged, no overflow_o.
REQ-026 Simultaneous push and pop when empty SHALL push only; pop is impossible because rx_valid_o=0.
REQ-027 Read and write pointers SHALL be $clog2(FifoDepth)+1 bits and wrap modulo 2*FifoDepth.
- Full: MSBs differ and LSBs are equal.
- Empty: pointers equal.
REQ-028 rx_ready_i asserted while rx_valid_o=0 SHALL have no effect.

Reset
REQ-029 While rst_sys_i=1 at a clock edge, the block SHALL reset as follows:
- FSM to IDLE; counter, shift register and pointers to 0.
- Synchronizer and edge-detect flops to 1.
- rx_valid_o=0, rx_level_o=0, rx_busy_o=0, frame_err_o=0, overflow_o=0, rx_data_o=8'h00.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no push and no error pulse.
- If the line is still low when reset deasserts, no frame starts until the next 1->0 edge.

Verification (ClockFrequency=1_000_000, BaudRate=100_000, ClksPerBit=10, FifoDepth=4)
REQ-031 Send 8'hA5 as 8N1 with rx_ready_i=0.
- Required: rx_valid_o=1 and rx_data_o=8'hA5 one cycle after the stop sample; rx_level_o=1; no error pulses.
REQ-032 Send 5 bytes 8'h01..8'h05 with rx_ready_i=0.
- Required: 4th byte makes rx_level_o=4; 5th byte gives exactly one overflow_o pulse.
- Then popping yields 01, 02, 03, 04.
REQ-033 Drive a 3-cycle low glitch on uart_rx_i.
- Required: return to IDLE at the mid-start sample; rx_busy_o drops; no push, no error pulse.
REQ-034 Send 8'h3C with the stop bit held low, then 8'h7E normally.
- Required: one frame_err_o pulse and no push for 8'h3C; 8'h7E received correctly after a line-high period followed by a new 1->0 edge.
REQ-035 With FIFO full, pop in the same cycle a new byte is pushed.
- Required: rx_level_o stays 4; no overflow_o; the new byte is read out last.
REQ-036 Assert rst_sys_i during data bit 4.
- Required: all outputs at reset values next cycle; the following frame 8'hC3 is received intact.
